// File: rtl/csd_partial_accum_if.sv
// Handshake bundle between a product-beat source / result consumer and csd_partial_accum.
// The accumulator uses the slave side; the feeder/consumer side uses master.
interface csd_partial_accum_if #(
    parameter int PROD_WIDTH  = 32,
    parameter int ACCUM_WIDTH = 48,
    parameter int LEN_WIDTH   = 8
);
    logic                          start;
    logic [LEN_WIDTH-1:0]          vec_len;
    logic                          sparse_en;
    logic                          in_valid;
    logic                          in_ready;
    logic signed [PROD_WIDTH-1:0]  prod_data;
    logic                          prod_hi;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [ACCUM_WIDTH-1:0] out_lsp;
    logic signed [ACCUM_WIDTH-1:0] out_msp;
    logic                          out_sparse;
    logic                          overflow;
    logic                          busy;

    modport master (
        output start, vec_len, sparse_en, in_valid, prod_data, prod_hi, out_ready,
        input  in_ready, out_valid, out_lsp, out_msp, out_sparse, overflow, busy
    );

    modport slave (
        input  start, vec_len, sparse_en, in_valid, prod_data, prod_hi, out_ready,
        output in_ready, out_valid, out_lsp, out_msp, out_sparse, overflow, busy
    );
endinterface

// File: rtl/csd_partial_accum.sv
// Accumulates a job of signed product beats into LSP/MSP partial sums and holds the
// finished pair behind a valid/ready handshake for the sparse reduction stage.
module csd_partial_accum #(
    parameter int PROD_WIDTH  = 32,
    parameter int ACCUM_WIDTH = 48,
    parameter int LEN_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    csd_partial_accum_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                        state;
    logic [LEN_WIDTH-1:0]          len_q;
    logic [LEN_WIDTH-1:0]          cnt;
    logic [LEN_WIDTH-1:0]          cnt_nxt;
    logic                          sparse_q;
    logic signed [ACCUM_WIDTH-1:0] lsp_acc;
    logic signed [ACCUM_WIDTH-1:0] msp_acc;
    logic signed [ACCUM_WIDTH-1:0] ext;
    logic signed [ACCUM_WIDTH-1:0] add_a;
    logic signed [ACCUM_WIDTH-1:0] sum;
    logic                          ovf;
    logic                          out_valid_q;
    logic                          busy_q;
    logic                          take_beat;
    logic                          to_msp;

    function automatic logic signed [ACCUM_WIDTH-1:0] sext(input logic signed [PROD_WIDTH-1:0] v);
        return ACCUM_WIDTH'(v);
    endfunction

    // Same-sign operands producing an opposite-sign result means the wrap lost information.
    function automatic logic add_ovf(input logic signed [ACCUM_WIDTH-1:0] a,
                                     input logic signed [ACCUM_WIDTH-1:0] b,
                                     input logic signed [ACCUM_WIDTH-1:0] s);
        return (a[ACCUM_WIDTH-1] == b[ACCUM_WIDTH-1]) && (s[ACCUM_WIDTH-1] != a[ACCUM_WIDTH-1]);
    endfunction

    assign to_msp    = sparse_q && bus.prod_hi;
    assign ext       = sext(bus.prod_data);
    assign add_a     = to_msp ? msp_acc : lsp_acc;
    assign sum       = add_a + ext;
    assign take_beat = (state == ACCUM) && bus.in_valid;
    assign cnt_nxt   = cnt + LEN_WIDTH'(1);

    assign bus.in_ready   = (state == ACCUM);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_lsp    = lsp_acc;
    assign bus.out_msp    = msp_acc;
    assign bus.out_sparse = sparse_q;
    assign bus.overflow   = ovf;
    assign bus.busy       = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len_q       <= '0;
            cnt         <= '0;
            sparse_q    <= 1'b0;
            lsp_acc     <= '0;
            msp_acc     <= '0;
            ovf         <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    if (bus.start) begin
                        len_q    <= bus.vec_len;
                        sparse_q <= bus.sparse_en;
                        lsp_acc  <= '0;
                        msp_acc  <= '0;
                        ovf      <= 1'b0;
                        cnt      <= '0;
                        busy_q   <= 1'b1;
                        state    <= (bus.vec_len != '0) ? ACCUM : HOLD;
                    end
                end
                ACCUM: begin
                    if (take_beat) begin
                        if (to_msp) msp_acc <= sum;
                        else        lsp_acc <= sum;
                        if (add_ovf(add_a, ext, sum)) ovf <= 1'b1;
                        cnt <= cnt_nxt;
                        if (cnt_nxt == len_q) begin
                            state       <= HOLD;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // A zero-length job enters HOLD straight from IDLE; raise valid one cycle later.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
